// File: rtl/cla16_mp_seq_if.sv
// Request/result bundle for the multi-precision add/subtract controller.
// The master drives the operands and start; the slave returns status and result.
interface cla16_mp_seq_if #(
  parameter int WORDS = 4
);
  logic                 start;
  logic                 sub;
  logic [16*WORDS-1:0]  op_a;
  logic [16*WORDS-1:0]  op_b;
  logic                 busy;
  logic                 done;
  logic [16*WORDS-1:0]  result;
  logic                 carry_out;
  logic                 overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/cla16_mp_seq.sv
// Sequential multi-precision add/subtract built around one 16-bit
// carry-lookahead adder. Operands are consumed one 16-bit word per cycle,
// least significant word first, with the carry chained through a register.

// 16-bit carry-lookahead adder: four 4-bit groups with group generate and
// propagate terms feeding a lookahead carry between groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        C
);
  logic [15:0] p;
  logic [15:0] g;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  assign p = a ^ b;
  assign g = a & b;

  // Group generate/propagate, lookahead group carries, then in-group carries.
  always_comb begin
    gg = '0;
    gp = '1;
    c  = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        gp[k] = gp[k] & p[4*k+j];
      end
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
      for (int unsigned j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign s = p ^ c[15:0];
  assign C = c[16];
endmodule

module cla16_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cla16_mp_seq_if.slave  bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [15:0]     a_q   [WORDS];
  logic [15:0]     b_q   [WORDS];
  logic [15:0]     res_q [WORDS];
  logic            sub_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic [IW-1:0]   idx_q;

  logic [15:0]     a_w;
  logic [15:0]     b_w;
  logic [15:0]     s_w;
  logic            c_w;
  logic            last;

  // Subtraction is A + ~B + 1: B is inverted per word and the carry seeded with 1.
  assign a_w  = a_q[idx_q];
  assign b_w  = sub_q ? ~b_q[idx_q] : b_q[idx_q];
  assign last = (idx_q == IW'(WORDS-1));

  cla16 u_add (
    .a   (a_w),
    .b   (b_w),
    .cin (carry_q),
    .s   (s_w),
    .C   (c_w)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, then one word written per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        a_q[w]   <= '0;
        b_q[w]   <= '0;
        res_q[w] <= '0;
      end
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
              a_q[w] <= bus.op_a[16*w +: 16];
              b_q[w] <= bus.op_b[16*w +: 16];
            end
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q[idx_q] <= s_w;
          carry_q      <= c_w;
          if (last) begin
            cout_q <= c_w;
            ovf_q  <= (a_w[15] == b_w[15]) && (s_w[15] != a_w[15]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the result words onto the bus.
  always_comb begin
    bus.result = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      bus.result[16*w +: 16] = res_q[w];
    end
  end

  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla16_mp_seq.sv
// Bench for cla16_mp_seq (WORDS=4): directed corner cases plus random
// operations checked through an expected-result queue.
module tb_cla16_mp_seq;
  localparam int WORDS = 4;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cla16_mp_seq_if #(.WORDS(WORDS)) bus ();

  cla16_mp_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t        e;
    logic [63:0] bi;
    logic [64:0] sum;
    bi    = s ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bi} + {64'd0, s};
    e.res = sum[63:0];
    e.co  = sum[64];
    e.ov  = (a[63] == bi[63]) && (sum[63] != a[63]);
    return e;
  endfunction

  // Compare every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("carry_out", {63'd0, bus.carry_out}, {63'd0, e.co});
        chk("overflow", {63'd0, bus.overflow}, {63'd0, e.ov});
        chk("busy_in_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input logic s, input bit expect_it);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.op_a  = a;
    bus.op_b  = b;
    if (expect_it) sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    drive_start(a, b, s, 1'b1);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    #12;
    chk("rst_result", bus.result, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_carry", {63'd0, bus.carry_out}, 64'd0);
    chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: busy through E0..E4, done only in the cycle after E4.
    drive_start(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1);
    for (int i = 0; i < WORDS; i++) begin
      chk("lat_busy", {63'd0, bus.busy}, 64'd1);
      chk("lat_done", {63'd0, bus.done}, 64'd0);
      @(posedge clk);
      #1;
    end
    chk("lat_done_hi", {63'd0, bus.done}, 64'd1);
    chk("lat_busy_lo", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    do_op(64'h0, 64'h1, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);

    // A start during RUN must be ignored.
    drive_start(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.op_a  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.op_b  = 64'h5555_5555_5555_5555;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-RUN: immediate zeroing, no done afterwards.
    drive_start(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_carry", {63'd0, bus.carry_out}, 64'd0);
    chk("abort_ovf", {63'd0, bus.overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(64'h0000_0001_0000_0002, 64'h0000_0003_FFFF_FFFF, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      do_op(a, b, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
